// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU-control issue stage: control codes, aluop and
// func7 encodings, and the execute-occupancy class of a control code.
package alu_ctrl_pkg;

  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_AND    = 5'd2;
  localparam logic [4:0] ALU_OR     = 5'd3;
  localparam logic [4:0] ALU_XOR    = 5'd4;
  localparam logic [4:0] ALU_BGE    = 5'd5;
  localparam logic [4:0] ALU_BLTU   = 5'd6;
  localparam logic [4:0] ALU_BGEU   = 5'd7;
  localparam logic [4:0] ALU_SLL    = 5'd8;
  localparam logic [4:0] ALU_SRL    = 5'd9;
  localparam logic [4:0] ALU_SRA    = 5'd10;
  localparam logic [4:0] ALU_SLT    = 5'd11;  // shared with BLT
  localparam logic [4:0] ALU_SLTU   = 5'd12;
  localparam logic [4:0] ALU_BEQ    = 5'd13;
  localparam logic [4:0] ALU_BNE    = 5'd14;
  localparam logic [4:0] ALU_MUL    = 5'd16;
  localparam logic [4:0] ALU_MULH   = 5'd17;
  localparam logic [4:0] ALU_MULHSU = 5'd18;
  localparam logic [4:0] ALU_MULHU  = 5'd19;
  localparam logic [4:0] ALU_DIV    = 5'd20;
  localparam logic [4:0] ALU_DIVU   = 5'd21;
  localparam logic [4:0] ALU_REM    = 5'd22;
  localparam logic [4:0] ALU_REMU   = 5'd23;

  localparam logic [1:0] AOP_MEM    = 2'b00;
  localparam logic [1:0] AOP_BRANCH = 2'b01;
  localparam logic [1:0] AOP_RTYPE  = 2'b10;
  localparam logic [1:0] AOP_ITYPE  = 2'b11;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;
  localparam logic [6:0] F7_MEXT = 7'h01;

  typedef enum logic [1:0] {
    LAT_SINGLE = 2'd0,
    LAT_MUL    = 2'd1,
    LAT_DIV    = 2'd2
  } lat_class_e;

  // Codes 16-19 are multiplies, 20-23 divides/remainders, the rest single-cycle.
  function automatic lat_class_e lat_class(input logic [4:0] code);
    lat_class_e cls;
    cls = LAT_SINGLE;
    if (code[4] && !code[3]) begin
      cls = code[2] ? LAT_DIV : LAT_MUL;
    end
    return cls;
  endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational decode of {aluop, func3, func7} into a 5-bit ALU control code.
// RV32M ops decode only when ALU_CTRL_MEXT_EN is defined.
module alu_ctrl_dec
  import alu_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  output logic [4:0] alu_ctrl,
  output logic       illegal
);

  function automatic logic [4:0] std_op(input logic [2:0] f3);
    logic [4:0] op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  always_comb begin
    alu_ctrl = ALU_ADD;
    illegal  = 1'b0;
    case (aluop)
      AOP_MEM: alu_ctrl = ALU_ADD;
      AOP_BRANCH: begin
        case (func3)
          3'b000:  alu_ctrl = ALU_BEQ;
          3'b001:  alu_ctrl = ALU_BNE;
          3'b100:  alu_ctrl = ALU_SLT;
          3'b101:  alu_ctrl = ALU_BGE;
          3'b110:  alu_ctrl = ALU_BLTU;
          3'b111:  alu_ctrl = ALU_BGEU;
          default: illegal  = 1'b1;
        endcase
      end
      AOP_RTYPE: begin
        if (func7 == F7_BASE) begin
          alu_ctrl = std_op(func3);
        end else if (func7 == F7_ALT) begin
          case (func3)
            3'b000:  alu_ctrl = ALU_SUB;
            3'b101:  alu_ctrl = ALU_SRA;
            default: illegal  = 1'b1;
          endcase
`ifdef ALU_CTRL_MEXT_EN
        end else if (func7 == F7_MEXT) begin
          alu_ctrl = {2'b10, func3};
`endif
        end else begin
          illegal = 1'b1;
        end
      end
      default: begin
        // I-type: func7 is immediate bits, meaningful only for the shifts.
        case (func3)
          3'b001: begin
            if (func7 == F7_BASE) alu_ctrl = ALU_SLL;
            else                  illegal  = 1'b1;
          end
          3'b101: begin
            if (func7 == F7_BASE)     alu_ctrl = ALU_SRL;
            else if (func7 == F7_ALT) alu_ctrl = ALU_SRA;
            else                      illegal  = 1'b1;
          end
          default: alu_ctrl = std_op(func3);
        endcase
      end
    endcase
    if (illegal) alu_ctrl = ALU_ADD;
  end

endmodule

// File: rtl/alu_ctrl_issue.sv
// Registered ALU-control issue stage: one-entry output buffer with valid/ready
// on both sides and MUL/DIV occupancy throttling (ALU_CTRL_MEXT_EN).
module alu_ctrl_issue
  import alu_ctrl_pkg::*;
#(
  parameter int TAG_W   = 5,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_aluop,
  input  logic [2:0]       in_func3,
  input  logic [6:0]       in_func7,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_alu_ctrl,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  output logic             busy
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  logic [4:0]       dec_ctrl;
  logic             dec_illegal;
  logic             hold_valid_q, hold_valid_d;
  logic [4:0]       ctrl_q, ctrl_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             handoff;

  alu_ctrl_dec u_dec (
    .aluop    (in_aluop),
    .func3    (in_func3),
    .func7    (in_func7),
    .alu_ctrl (dec_ctrl),
    .illegal  (dec_illegal)
  );

  // Handshake: a transfer happens on a side in any cycle where its valid and
  // ready are both high; valid never depends on ready, and in_ready may rise
  // in the same cycle the held op is handed off.
  assign busy      = (cnt != '0);
  assign out_valid = hold_valid_q && !busy;
  assign in_ready  = !hold_valid_q || (out_valid && out_ready);
  assign accept    = in_valid && in_ready;
  assign handoff   = out_valid && out_ready;

  assign out_alu_ctrl = ctrl_q;
  assign out_tag      = tag_q;
  assign out_illegal  = illegal_q;

  always_comb begin
    hold_valid_d = hold_valid_q;
    ctrl_d       = ctrl_q;
    tag_d        = tag_q;
    illegal_d    = illegal_q;
    if (flush) begin
      // Flush wins over a same-cycle accept: the incoming op is dropped.
      hold_valid_d = 1'b0;
    end else if (accept) begin
      hold_valid_d = 1'b1;
      ctrl_d       = dec_ctrl;
      tag_d        = in_tag;
      illegal_d    = dec_illegal;
    end else if (handoff) begin
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_valid_q <= 1'b0;
      ctrl_q       <= '0;
      tag_q        <= '0;
      illegal_q    <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      ctrl_q       <= ctrl_d;
      tag_q        <= tag_d;
      illegal_q    <= illegal_d;
    end
  end

`ifdef ALU_CTRL_MEXT_EN
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Handoff only occurs with cnt_q == 0, so load and decrement never overlap.
  always_comb begin
    cnt_d = cnt_q;
    if (handoff) begin
      case (lat_class(ctrl_q))
        LAT_MUL: cnt_d = MUL_LOAD;
        LAT_DIV: cnt_d = DIV_LOAD;
        default: cnt_d = '0;
      endcase
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
`else
  // No multi-cycle unit behind this stage: occupancy is permanently zero.
  assign cnt = '0;
`endif

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Self-checking bench for alu_ctrl_issue: scoreboard of expected issued ops
// plus per-scenario inline checks of handshake timing.
module tb_alu_ctrl_issue;

  localparam int TAG_W   = 5;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 32;
  localparam int EW      = TAG_W + 6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_aluop;
  logic [2:0]       in_func3;
  logic [6:0]       in_func7;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [4:0]       out_alu_ctrl;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;
  logic             busy;

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int handoffs = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] sb_exp;

  alu_ctrl_issue #(
    .TAG_W   (TAG_W),
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_aluop     (in_aluop),
    .in_func3     (in_func3),
    .in_func7     (in_func7),
    .in_tag       (in_tag),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_alu_ctrl (out_alu_ctrl),
    .out_tag      (out_tag),
    .out_illegal  (out_illegal),
    .busy         (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      handoffs++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got ill=%0b ctrl=%0d tag=%0d, required no op",
                 out_illegal, out_alu_ctrl, out_tag);
      end else begin
        sb_exp = exp_q.pop_front();
        if ({out_illegal, out_alu_ctrl, out_tag} !== sb_exp) begin
          errors++;
          $display("FAIL sb_op: got ill=%0b ctrl=%0d tag=%0d, required ill=%0b ctrl=%0d tag=%0d",
                   out_illegal, out_alu_ctrl, out_tag,
                   sb_exp[EW-1], sb_exp[EW-2:TAG_W], sb_exp[TAG_W-1:0]);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Called just after a posedge; returns just after the posedge that accepted.
  task automatic drive_op(input logic [1:0] a, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [TAG_W-1:0] tag, input logic [4:0] exp_ctrl,
                          input logic exp_ill, input logic push, output int waited);
    waited   = 0;
    in_valid = 1'b1;
    in_aluop = a;
    in_func3 = f3;
    in_func7 = f7;
    in_tag   = tag;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 100) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, waited);
    end else if (push) begin
      exp_q.push_back({exp_ill, exp_ctrl, tag});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int w;
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_aluop  = 2'b10;
    in_func3  = 3'b000;
    in_func7  = 7'h20;
    in_tag    = 5'd9;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_alu_ctrl !== 5'd0 ||
        out_tag !== '0 || out_illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got valid=%0b busy=%0b ctrl=%0d tag=%0d ill=%0b, required all 0",
               out_valid, busy, out_alu_ctrl, out_tag, out_illegal);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_op(2'b10, 3'b000, 7'h20, 5'd7, 5'd1, 1'b0, 1'b1, w);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_alu_ctrl !== 5'd1 || out_tag !== 5'd7) begin
      errors++;
      $display("FAIL first_op: got valid=%0b ctrl=%0d tag=%0d, required valid=1 ctrl=1 tag=7",
               out_valid, out_alu_ctrl, out_tag);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_streaming();
    logic [2:0] f3s [8] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
    logic [6:0] f7s [8] = '{7'h55, 7'h00, 7'h7f, 7'h00, 7'h33, 7'h20, 7'h00, 7'h12};
    logic [4:0] exps[8] = '{5'd0, 5'd8, 5'd11, 5'd12, 5'd4, 5'd10, 5'd3, 5'd2};
    int w, wsum, c0, h0;
    wsum = 0;
    c0   = cyc;
    h0   = handoffs;
    for (int i = 0; i < 8; i++) begin
      drive_op(2'b11, f3s[i], f7s[i], TAG_W'(16 + i), exps[i], 1'b0, 1'b1, w);
      wsum += w;
    end
    @(posedge clk);
    #1;
    checks++;
    if (wsum != 0 || (cyc - c0) != 9 || (handoffs - h0) != 8) begin
      errors++;
      $display("FAIL stream_rate: got stalls=%0d cycles=%0d handoffs=%0d, required 0, 9, 8",
               wsum, cyc - c0, handoffs - h0);
    end
  endtask

  task automatic test_illegal();
    int w;
    drive_op(2'b10, 3'b111, 7'h20, 5'd1, 5'd0, 1'b1, 1'b1, w);
    @(negedge clk);
    checks++;
    if (out_illegal !== 1'b1 || out_alu_ctrl !== 5'd0) begin
      errors++;
      $display("FAIL illegal_rtype: got ill=%0b ctrl=%0d, required ill=1 ctrl=0",
               out_illegal, out_alu_ctrl);
    end
    @(posedge clk);
    #1;
    drive_op(2'b01, 3'b010, 7'h00, 5'd2,  5'd0,  1'b1, 1'b1, w);
    drive_op(2'b01, 3'b011, 7'h00, 5'd3,  5'd0,  1'b1, 1'b1, w);
    drive_op(2'b01, 3'b111, 7'h00, 5'd4,  5'd7,  1'b0, 1'b1, w);
    drive_op(2'b01, 3'b000, 7'h00, 5'd5,  5'd13, 1'b0, 1'b1, w);
    drive_op(2'b01, 3'b001, 7'h00, 5'd6,  5'd14, 1'b0, 1'b1, w);
    drive_op(2'b01, 3'b100, 7'h00, 5'd7,  5'd11, 1'b0, 1'b1, w);
    drive_op(2'b01, 3'b101, 7'h00, 5'd8,  5'd5,  1'b0, 1'b1, w);
    drive_op(2'b01, 3'b110, 7'h00, 5'd9,  5'd6,  1'b0, 1'b1, w);
    drive_op(2'b10, 3'b101, 7'h00, 5'd10, 5'd9,  1'b0, 1'b1, w);
    drive_op(2'b10, 3'b010, 7'h00, 5'd11, 5'd11, 1'b0, 1'b1, w);
    drive_op(2'b10, 3'b000, 7'h02, 5'd12, 5'd0,  1'b1, 1'b1, w);
    drive_op(2'b11, 3'b001, 7'h20, 5'd13, 5'd0,  1'b1, 1'b1, w);
    drive_op(2'b11, 3'b101, 7'h10, 5'd14, 5'd0,  1'b1, 1'b1, w);
    drive_op(2'b00, 3'b011, 7'h7f, 5'd15, 5'd0,  1'b0, 1'b1, w);
`ifdef ALU_CTRL_MEXT_EN
    drive_op(2'b10, 3'b011, 7'h01, 5'd16, 5'd19, 1'b0, 1'b1, w);
`else
    drive_op(2'b10, 3'b000, 7'h01, 5'd16, 5'd0, 1'b1, 1'b1, w);
    @(negedge clk);
    checks++;
    if (out_illegal !== 1'b1 || out_alu_ctrl !== 5'd0) begin
      errors++;
      $display("FAIL mext_disabled: got ill=%0b ctrl=%0d, required ill=1 ctrl=0",
               out_illegal, out_alu_ctrl);
    end
    @(posedge clk);
    #1;
`endif
  endtask

  task automatic test_backpressure();
    int w;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    drive_op(2'b10, 3'b110, 7'h00, 5'd11, 5'd3, 1'b0, 1'b1, w);
    in_valid = 1'b1;
    in_aluop = 2'b10;
    in_func3 = 3'b100;
    in_func7 = 7'h00;
    in_tag   = 5'd12;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_alu_ctrl !== 5'd3 ||
          out_tag !== 5'd11 || out_illegal !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d got in_ready=%0b valid=%0b ctrl=%0d tag=%0d, required 0 1 3 11",
                 i, in_ready, out_valid, out_alu_ctrl, out_tag);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    drive_op(2'b10, 3'b100, 7'h00, 5'd12, 5'd4, 1'b0, 1'b1, w);
    checks++;
    if (w != 0) begin
      errors++;
      $display("FAIL bp_same_cycle: got accept wait=%0d, required 0", w);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_alu_ctrl !== 5'd4 || out_tag !== 5'd12) begin
      errors++;
      $display("FAIL bp_next: got valid=%0b ctrl=%0d tag=%0d, required 1 4 12",
               out_valid, out_alu_ctrl, out_tag);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_flush();
    int w;
    logic b0;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    drive_op(2'b00, 3'b000, 7'h00, 5'd13, 5'd0, 1'b0, 1'b0, w);
    b0       = busy;
    flush    = 1'b1;
    in_valid = 1'b1;
    in_aluop = 2'b01;
    in_func3 = 3'b000;
    in_func7 = 7'h00;
    in_tag   = 5'd14;
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== b0) begin
      errors++;
      $display("FAIL flush_hold: got valid=%0b busy=%0b, required valid=0 busy=%0b",
               out_valid, busy, b0);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_ready: got in_ready=%0b, required 1", in_ready);
    end
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop: got valid=%0b, required 0", out_valid);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

`ifdef ALU_CTRL_MEXT_EN
  task automatic test_mext();
    int w, k, stall;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1;
    drive_op(2'b10, 3'b100, 7'h01, 5'd3, 5'd20, 1'b0, 1'b1, w);
    drive_op(2'b00, 3'b000, 7'h00, 5'd4, 5'd0,  1'b0, 1'b1, w);
    k = 0;
    stall = 0;
    while (k < 64) begin
      @(negedge clk);
      k++;
      if (out_valid) break;
      if (busy) stall++;
    end
    checks++;
    if (stall != DIV_LAT - 1 || k != DIV_LAT) begin
      errors++;
      $display("FAIL div_stall: got busy=%0d valid_at=%0d, required busy=%0d valid_at=%0d",
               stall, k, DIV_LAT - 1, DIV_LAT);
    end
    @(posedge clk);
    #1;
    drive_op(2'b10, 3'b000, 7'h01, 5'd5, 5'd16, 1'b0, 1'b1, w);
    drive_op(2'b00, 3'b000, 7'h00, 5'd6, 5'd0,  1'b0, 1'b1, w);
    k = 0;
    stall = 0;
    while (k < 64) begin
      @(negedge clk);
      k++;
      if (out_valid) break;
      if (busy) stall++;
    end
    checks++;
    if (stall != MUL_LAT - 1 || k != MUL_LAT) begin
      errors++;
      $display("FAIL mul_stall: got busy=%0d valid_at=%0d, required busy=%0d valid_at=%0d",
               stall, k, MUL_LAT - 1, MUL_LAT);
    end
    @(posedge clk);
    #1;
    drive_op(2'b10, 3'b111, 7'h01, 5'd8, 5'd23, 1'b0, 1'b1, w);
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rem_busy: got busy=%0b, required 1", busy);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_op: got busy=%0b valid=%0b, required 0 0", busy, out_valid);
    end
    @(posedge clk);
    #1;
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    int n;
    test_reset();
    test_streaming();
    test_illegal();
    test_backpressure();
    test_flush();
`ifdef ALU_CTRL_MEXT_EN
    test_mext();
`endif
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d ops outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
